ps2_frame_receiver: RTL and testbench



---
 rtl/ps2_frame_receiver_if.sv | 22 ++
 rtl/ps2_frame_receiver.sv | 142 ++++++++++++++
 tb/tb_ps2_frame_receiver.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_frame_receiver_if.sv
// Key-event bus between the PS/2 frame receiver and the keyboard scancode path.
// The receiver side takes the raw pad lines and the enable, and drives the event outputs.
interface ps2_frame_receiver_if;
  logic       ps2clk_in;
  logic       ps2data_in;
  logic       enable_rcv;
  logic       kb_interrupt;
  logic [7:0] scancode;
  logic       extended;
  logic       released;
  logic       frame_error;

  modport master (
    input  ps2clk_in, ps2data_in, enable_rcv,
    output kb_interrupt, scancode, extended, released, frame_error
  );

  modport slave (
    output ps2clk_in, ps2data_in, enable_rcv,
    input  kb_interrupt, scancode, extended, released, frame_error
  );
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: synchronise and deglitch the pad lines, deserialise
// 11-bit frames, check parity/stop, fold E0/F0 prefixes into one key event per pulse.
module ps2_frame_receiver #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 56000
) (
  input logic                   clk,
  input logic                   rst_n,
  ps2_frame_receiver_if.master  bus
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [15:0] TIMEOUT_CNT = TIMEOUT[15:0];

  logic [1:0]            clk_sync;
  logic [1:0]            data_sync;
  logic [FILTER_LEN-1:0] clk_samples;
  logic [FILTER_LEN-1:0] data_samples;
  logic                  clk_filt;
  logic                  data_filt;
  logic                  fall;

  state_t      state;
  logic [2:0]  bitcnt;
  logic [7:0]  shift;
  logic        parity_bit;
  logic        ext_pending;
  logic        rel_pending;
  logic [15:0] timer;

  // Filtered levels move only on a unanimous sample window; fall is raised in the
  // same cycle the filtered clock drops, so it lines up with the fresh filtered data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync     <= '1;
      data_sync    <= '1;
      clk_samples  <= '1;
      data_samples <= '1;
      clk_filt     <= 1'b1;
      data_filt    <= 1'b1;
      fall         <= 1'b0;
    end else begin
      clk_sync     <= {clk_sync[0], bus.ps2clk_in};
      data_sync    <= {data_sync[0], bus.ps2data_in};
      clk_samples  <= {clk_samples[FILTER_LEN-2:0], clk_sync[1]};
      data_samples <= {data_samples[FILTER_LEN-2:0], data_sync[1]};
      if (&clk_samples)
        clk_filt <= 1'b1;
      else if (~|clk_samples)
        clk_filt <= 1'b0;
      if (&data_samples)
        data_filt <= 1'b1;
      else if (~|data_samples)
        data_filt <= 1'b0;
      fall <= clk_filt & ~|clk_samples;
    end
  end

  // Frame FSM; disable beats an edge, and an edge beats the inactivity timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      bitcnt           <= 3'd0;
      shift            <= 8'h00;
      parity_bit       <= 1'b0;
      ext_pending      <= 1'b0;
      rel_pending      <= 1'b0;
      timer            <= 16'd0;
      bus.kb_interrupt <= 1'b0;
      bus.frame_error  <= 1'b0;
      bus.scancode     <= 8'h00;
      bus.extended     <= 1'b0;
      bus.released     <= 1'b0;
    end else begin
      bus.kb_interrupt <= 1'b0;
      bus.frame_error  <= 1'b0;
      if (!bus.enable_rcv) begin
        state       <= IDLE;
        timer       <= 16'd0;
        bitcnt      <= 3'd0;
        ext_pending <= 1'b0;
        rel_pending <= 1'b0;
      end else if (fall) begin
        timer <= 16'd0;
        case (state)
          IDLE: begin
            if (!data_filt) begin
              state  <= DATA;
              bitcnt <= 3'd0;
            end
          end
          DATA: begin
            shift  <= {data_filt, shift[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_filt;
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data_filt && (^{shift, parity_bit})) begin
              if (shift == 8'hE0) begin
                ext_pending <= 1'b1;
              end else if (shift == 8'hF0) begin
                rel_pending <= 1'b1;
              end else begin
                bus.scancode     <= shift;
                bus.extended     <= ext_pending;
                bus.released     <= rel_pending;
                bus.kb_interrupt <= 1'b1;
                ext_pending      <= 1'b0;
                rel_pending      <= 1'b0;
              end
            end else begin
              bus.frame_error <= 1'b1;
              ext_pending     <= 1'b0;
              rel_pending     <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (timer == TIMEOUT_CNT) begin
          bus.frame_error <= 1'b1;
          ext_pending     <= 1'b0;
          rel_pending     <= 1'b0;
          state           <= IDLE;
          timer           <= 16'd0;
        end else begin
          timer <= timer + 16'd1;
        end
      end else begin
        timer <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver: a table of frames plus hand-built corner
// sequences, with expected key events queued on drive and matched as the DUT emits them.
module tb_ps2_frame_receiver;

  localparam int T       = 56000;
  localparam int LATENCY = 12;

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         bad_stop;
    bit         exp_evt;
    int         exp_kind;
    logic [7:0] exp_code;
    bit         exp_ext;
    bit         exp_rel;
  } vec_t;

  typedef struct {
    int         kind;
    logic [7:0] code;
    bit         ext;
    bit         rel;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   last_fall_cyc;
  int   checks;
  int   errors;
  bit   prev_int;
  bit   prev_err;
  ev_t  sb[$];
  ev_t  got;
  vec_t tbl[7];

  ps2_frame_receiver_if bus ();

  ps2_frame_receiver #(.FILTER_LEN(8), .TIMEOUT(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_event(input int kind, input logic [7:0] code, input bit ext, input bit rel);
    ev_t e;
    e.kind = kind;
    e.code = code;
    e.ext  = ext;
    e.rel  = rel;
    sb.push_back(e);
  endtask

  // Device-side frame: data changes while the clock is high, bit period 100 cycles.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit, input int drop_bit);
    logic [10:0] bits;
    logic        par;
    par = ~^b;
    if (bad_par)
      par = ~par;
    bits = {~bad_stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == drop_bit)
        bus.enable_rcv = 1'b0;
      bus.ps2data_in = bits[i];
      if (i == glitch_bit) begin
        wait_cycles(20);
        bus.ps2clk_in = 1'b0;
        wait_cycles(4);
        bus.ps2clk_in = 1'b1;
        wait_cycles(26);
      end else begin
        wait_cycles(50);
      end
      bus.ps2clk_in = 1'b0;
      last_fall_cyc = cyc;
      wait_cycles(50);
      bus.ps2clk_in = 1'b1;
    end
    bus.ps2data_in = 1'b1;
    wait_cycles(30);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.exp_evt)
      push_event(v.exp_kind, v.exp_code, v.exp_ext, v.exp_rel);
    send_frame(v.data, v.bad_par, v.bad_stop, 11, -1, -1);
  endtask

  // Scoreboard side: every pulse must match the head of the expected-event queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_int)
        checkOutput("int_width", int'(bus.kb_interrupt), 0);
      if (prev_err)
        checkOutput("err_width", int'(bus.frame_error), 0);
      if (bus.kb_interrupt || bus.frame_error) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event: got int=%0d err=%0d expected none",
                   bus.kb_interrupt, bus.frame_error);
        end else begin
          got = sb.pop_front();
          checkOutput("event_is_error", int'(bus.frame_error), int'(got.kind != 0));
          if (got.kind == 0) begin
            checkOutput("scancode", int'(bus.scancode), int'(got.code));
            checkOutput("extended", int'(bus.extended), int'(got.ext));
            checkOutput("released", int'(bus.released), int'(got.rel));
            checkOutput("int_latency", cyc - last_fall_cyc, LATENCY);
          end else if (got.kind == 1) begin
            checkOutput("err_latency", cyc - last_fall_cyc, LATENCY);
          end else begin
            checks++;
            if ((cyc - last_fall_cyc) < T + 11 || (cyc - last_fall_cyc) > T + 15) begin
              errors++;
              $display("[TB] FAIL timeout_latency: got %0d expected %0d..%0d",
                       cyc - last_fall_cyc, T + 11, T + 15);
            end
          end
        end
      end
    end
    prev_int = bus.kb_interrupt;
    prev_err = bus.frame_error;
  end

  initial begin
    cyc            = 0;
    checks         = 0;
    errors         = 0;
    last_fall_cyc  = 0;
    prev_int       = 1'b0;
    prev_err       = 1'b0;
    rst_n          = 1'b0;
    bus.ps2clk_in  = 1'b1;
    bus.ps2data_in = 1'b1;
    bus.enable_rcv = 1'b1;

    tbl[0] = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 0};
    tbl[1] = '{8'hE0, 0, 0, 0, 0, 8'h00, 0, 0};
    tbl[2] = '{8'hF0, 0, 0, 0, 0, 8'h00, 0, 0};
    tbl[3] = '{8'h75, 0, 0, 1, 0, 8'h75, 1, 1};
    tbl[4] = '{8'h75, 0, 0, 1, 0, 8'h75, 0, 0};
    tbl[5] = '{8'h1C, 1, 0, 1, 1, 8'h00, 0, 0};
    tbl[6] = '{8'h1C, 0, 1, 1, 1, 8'h00, 0, 0};

    wait_cycles(5);
    checkOutput("rst_int", int'(bus.kb_interrupt), 0);
    checkOutput("rst_err", int'(bus.frame_error), 0);
    checkOutput("rst_code", int'(bus.scancode), 0);
    checkOutput("rst_ext", int'(bus.extended), 0);
    checkOutput("rst_rel", int'(bus.released), 0);
    rst_n = 1'b1;
    wait_cycles(20);
    checkOutput("idle_int", int'(bus.kb_interrupt), 0);
    $display("[TB] reset released at cycle %0d", cyc);

    for (int i = 0; i < 7; i++)
      applyStimulus(tbl[i]);
    checkOutput("hold_code", int'(bus.scancode), 8'h75);
    checkOutput("hold_ext", int'(bus.extended), 0);
    checkOutput("table_drained", sb.size(), 0);

    $display("[TB] glitch sequence");
    bus.ps2clk_in = 1'b0;
    wait_cycles(4);
    bus.ps2clk_in = 1'b1;
    wait_cycles(30);
    push_event(0, 8'h2A, 0, 0);
    send_frame(8'h2A, 0, 0, 11, 3, -1);
    checkOutput("glitch_drained", sb.size(), 0);

    $display("[TB] timeout sequence");
    send_frame(8'hF0, 0, 0, 11, -1, -1);
    push_event(2, 8'h00, 0, 0);
    send_frame(8'h1C, 0, 0, 5, -1, -1);
    wait_cycles(60000);
    checkOutput("timeout_drained", sb.size(), 0);
    push_event(0, 8'h1C, 0, 0);
    send_frame(8'h1C, 0, 0, 11, -1, -1);

    $display("[TB] enable drop sequence");
    send_frame(8'h16, 0, 0, 11, -1, 4);
    wait_cycles(10);
    bus.enable_rcv = 1'b1;
    wait_cycles(20);
    checkOutput("disabled_code", int'(bus.scancode), 8'h1C);
    push_event(0, 8'h16, 0, 0);
    send_frame(8'h16, 0, 0, 11, -1, -1);

    $display("[TB] mid-frame reset sequence");
    send_frame(8'h1C, 0, 0, 6, -1, -1);
    rst_n = 1'b0;
    wait_cycles(3);
    checkOutput("midrst_code", int'(bus.scancode), 0);
    rst_n = 1'b1;
    wait_cycles(20);
    push_event(0, 8'h1C, 0, 0);
    send_frame(8'h1C, 0, 0, 11, -1, -1);

    wait_cycles(100);
    checkOutput("final_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
